// File: rtl/llm_params.sv
// Shared parameters and types for the data_ctrl command responder.
// Holds the command/completion records and the illegal-command check.
package llm_params;

   localparam int unsigned CHI_ADDR_WIDTH = 32;
   localparam int unsigned CHI_DATA_WIDTH = 64;
   localparam int unsigned PRIORITY_WIDTH = 4;

   typedef enum logic [3:0] {
      DcRead  = 4'd0,
      DcWrite = 4'd1
   } dc_op_e;

   typedef enum logic [1:0] {
      RobFree = 2'd0,
      RobWait = 2'd1,
      RobDone = 2'd2
   } rob_st_e;

   typedef struct packed {
      logic [CHI_DATA_WIDTH-1:0] data;
      logic [31:0]               pld;
      logic                      snp;
      logic [PRIORITY_WIDTH-1:0] prio;
      logic                      err;
   } dc_cpl_t;

   typedef struct packed {
      logic [CHI_ADDR_WIDTH-1:0] addr;
      logic [CHI_DATA_WIDTH-1:0] data;
      logic [7:0]                size;
      logic                      snp;
      logic [3:0]                typ;
      logic [31:0]               pld;
      logic [PRIORITY_WIDTH-1:0] prio;
   } dc_cmd_t;

   // Illegal: unknown opcode, zero size, or larger than one data beat.
   function automatic logic cmd_illegal(dc_cmd_t c);
      return (c.typ > 4'd1) || (c.size == 8'd0) || (c.size > 8'(CHI_DATA_WIDTH / 8));
   endfunction

endpackage

// File: rtl/llm_sync_fifo.sv
// Flop-based synchronous FIFO; ready is derived from registered occupancy only,
// so a same-cycle pop never raises wr_ready_o.
module llm_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_valid_i,
   output logic             wr_ready_o,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output logic [WIDTH-1:0] rd_data_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]    count_q, count_d;
   logic             push, pop;

   assign wr_ready_o = (count_q != (PtrW+1)'(DEPTH));
   assign rd_valid_o = (count_q != '0);
   assign rd_data_o  = mem_q[rd_ptr_q];
   assign push       = wr_valid_i && wr_ready_o;
   assign pop        = rd_ready_i && rd_valid_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data_i;
         wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + (PtrW+1)'(push) - (PtrW+1)'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/llm_dc_resp.sv
// data_ctrl command responder: input FIFO, tagged out-of-order memory issue,
// and an in-order completion reorder buffer indexed by memory tag.
module llm_dc_resp
   import llm_params::*;
#(
   parameter int unsigned IN_DEPTH  = 4,
   parameter int unsigned ROB_DEPTH = 8,
   parameter int unsigned TAG_W     = $clog2(ROB_DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHI_ADDR_WIDTH-1:0] dc_addr,
   input  logic [CHI_DATA_WIDTH-1:0] dc_data,
   input  logic [7:0]                dc_size,
   input  logic                      dc_snp,
   input  logic [3:0]                dc_type,
   input  logic [31:0]               dc_pld,
   input  logic [PRIORITY_WIDTH-1:0] dc_priority,
   input  logic                      dc_valid,
   output logic                      dc_ready,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic                      mem_req_we,
   output logic [CHI_ADDR_WIDTH-1:0] mem_req_addr,
   output logic [CHI_DATA_WIDTH-1:0] mem_req_wdata,
   output logic [TAG_W-1:0]          mem_req_tag,
   input  logic                      mem_rsp_valid,
   input  logic [TAG_W-1:0]          mem_rsp_tag,
   input  logic [CHI_DATA_WIDTH-1:0] mem_rsp_data,
   input  logic                      mem_rsp_err,
   output logic                      cpl_valid,
   input  logic                      cpl_ready,
   output logic [CHI_DATA_WIDTH-1:0] cpl_data,
   output logic [31:0]               cpl_pld,
   output logic                      cpl_snp,
   output logic [PRIORITY_WIDTH-1:0] cpl_priority,
   output logic                      cpl_err,
   output logic [TAG_W:0]            inflight,
   output logic                      proto_err
);

   dc_cmd_t    cmd_in, head;
   logic       head_vld, head_illegal, can_issue, issue, cpl_fire;

   rob_st_e    st_q   [ROB_DEPTH];
   rob_st_e    st_d   [ROB_DEPTH];
   dc_cpl_t    slot_q [ROB_DEPTH];
   dc_cpl_t    slot_d [ROB_DEPTH];
   logic       we_q   [ROB_DEPTH];
   logic       we_d   [ROB_DEPTH];

   logic [TAG_W-1:0] alloc_ptr_q, alloc_ptr_d;
   logic [TAG_W-1:0] cpl_ptr_q, cpl_ptr_d;
   logic [TAG_W:0]   inflight_q, inflight_d;
   logic             proto_err_q, proto_err_d;
   dc_cpl_t          cpl_sel;

   assign cmd_in = '{addr: dc_addr, data: dc_data, size: dc_size, snp: dc_snp,
                     typ: dc_type, pld: dc_pld, prio: dc_priority};

   llm_sync_fifo #(
      .WIDTH($bits(dc_cmd_t)),
      .DEPTH(IN_DEPTH)
   ) u_in_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid_i(dc_valid),
      .wr_ready_o(dc_ready),
      .wr_data_i (cmd_in),
      .rd_valid_o(head_vld),
      .rd_ready_i(issue),
      .rd_data_o (head)
   );

   // Illegal commands retire straight into the ROB without waiting for memory.
   assign head_illegal = cmd_illegal(head);
   assign can_issue    = head_vld && (st_q[alloc_ptr_q] == RobFree);
   assign issue        = can_issue && (head_illegal || mem_req_ready);

   assign mem_req_valid = can_issue && !head_illegal;
   assign mem_req_we    = mem_req_valid && (head.typ == DcWrite);
   assign mem_req_addr  = mem_req_valid ? head.addr : '0;
   assign mem_req_wdata = mem_req_valid ? head.data : '0;
   assign mem_req_tag   = mem_req_valid ? alloc_ptr_q : '0;

   assign cpl_sel      = slot_q[cpl_ptr_q];
   assign cpl_valid    = (st_q[cpl_ptr_q] == RobDone);
   assign cpl_fire     = cpl_valid && cpl_ready;
   assign cpl_data     = cpl_valid ? cpl_sel.data : '0;
   assign cpl_pld      = cpl_valid ? cpl_sel.pld : '0;
   assign cpl_snp      = cpl_valid && cpl_sel.snp;
   assign cpl_priority = cpl_valid ? cpl_sel.prio : '0;
   assign cpl_err      = cpl_valid && cpl_sel.err;

   assign inflight  = inflight_q;
   assign proto_err = proto_err_q;

   // Issue hits a FREE slot, response a WAIT slot, completion a DONE slot,
   // so the three updates never target the same entry in one cycle.
   always_comb begin
      st_d        = st_q;
      slot_d      = slot_q;
      we_d        = we_q;
      alloc_ptr_d = alloc_ptr_q;
      cpl_ptr_d   = cpl_ptr_q;
      proto_err_d = proto_err_q;
      if (issue) begin
         st_d[alloc_ptr_q]   = head_illegal ? RobDone : RobWait;
         slot_d[alloc_ptr_q] = '{data: '0, pld: head.pld, snp: head.snp, prio: head.prio,
                                 err: head_illegal};
         we_d[alloc_ptr_q]   = (head.typ == DcWrite);
         alloc_ptr_d         = alloc_ptr_q + TAG_W'(1);
      end
      if (mem_rsp_valid) begin
         if (st_q[mem_rsp_tag] == RobWait) begin
            st_d[mem_rsp_tag]      = RobDone;
            slot_d[mem_rsp_tag].data = (we_q[mem_rsp_tag] || mem_rsp_err) ? '0 : mem_rsp_data;
            slot_d[mem_rsp_tag].err  = mem_rsp_err;
         end else begin
            proto_err_d = 1'b1;
         end
      end
      if (cpl_fire) begin
         st_d[cpl_ptr_q] = RobFree;
         cpl_ptr_d       = cpl_ptr_q + TAG_W'(1);
      end
      inflight_d = inflight_q + (TAG_W+1)'(issue) - (TAG_W+1)'(cpl_fire);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(ROB_DEPTH); i++) begin
            st_q[i]   <= RobFree;
            slot_q[i] <= '0;
            we_q[i]   <= 1'b0;
         end
         alloc_ptr_q <= '0;
         cpl_ptr_q   <= '0;
         inflight_q  <= '0;
         proto_err_q <= 1'b0;
      end else begin
         st_q        <= st_d;
         slot_q      <= slot_d;
         we_q        <= we_d;
         alloc_ptr_q <= alloc_ptr_d;
         cpl_ptr_q   <= cpl_ptr_d;
         inflight_q  <= inflight_d;
         proto_err_q <= proto_err_d;
      end
   end

endmodule
